// File: rtl/sum_acc_pkg.sv
// Shared types and default sizes for the sum accumulator.
package sum_acc_pkg;

  typedef enum logic [1:0] {IDLE, ACC, DONE} sum_acc_state_t;

  localparam int SUM_W_DEF     = 5;
  localparam int ACC_W_DEF     = 8;
  localparam int BURST_LEN_DEF = 4;

endpackage

// File: rtl/sum_accumulator.sv
// Collects a burst of adder sums over valid/ready and presents the total and count.
// Optional sticky carry-out flag is enabled by defining SUM_ACCUMULATOR_OVF_EN.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int SUM_W     = SUM_W_DEF,
  parameter int ACC_W     = ACC_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int CNT_W     = $clog2(BURST_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] in_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [CNT_W-1:0] out_count,
  output logic             busy,
  output logic             overflow
);

  sum_acc_state_t   state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_sum;
  logic [CNT_W-1:0] count_q, count_d;
  logic             accept;
  logic             last_sample;
  logic             clear;

  // in_ready depends on state alone, so an accept is simply a valid cycle in ACC
  assign accept      = (state_q == ACC) && in_valid;
  assign last_sample = (count_q == CNT_W'(BURST_LEN - 1));
  assign clear       = (state_q == IDLE) && start;

`ifdef SUM_ACCUMULATOR_OVF_EN
  logic carry;
  logic ovf_q, ovf_d;

  assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, ACC_W'(in_sum)};

  always_comb begin
    ovf_d = ovf_q;
    if (clear) begin
      ovf_d = 1'b0;
    end else if (accept && carry) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow = ovf_q;
`else
  assign acc_sum  = acc_q + ACC_W'(in_sum);
  assign overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACC;
      ACC:     if (accept && last_sample) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Results stay put in IDLE and DONE until the next start clears them
  always_comb begin
    acc_d   = acc_q;
    count_d = count_q;
    if (clear) begin
      acc_d   = '0;
      count_d = '0;
    end else if (accept) begin
      acc_d   = acc_sum;
      count_d = count_q + CNT_W'(1);
    end
  end

  always_comb begin
    in_ready  = (state_q == ACC);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign out_acc   = acc_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Scoreboarded random/directed bench for sum_accumulator at ACC_W=8 and ACC_W=6.
// Overflow expectations follow SUM_ACCUMULATOR_OVF_EN.
module tb_sum_accumulator;

  localparam int BL    = 4;
  localparam int CW    = $clog2(BL + 1);
  localparam int ACC_A = 8;
  localparam int ACC_B = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             in_valid = 1'b0;
  logic [4:0]       in_sum = '0;
  logic             out_ready = 1'b0;

  logic             in_ready_a, out_valid_a, busy_a, overflow_a;
  logic [ACC_A-1:0] out_acc_a;
  logic [CW-1:0]    out_count_a;
  logic             in_ready_b, out_valid_b, busy_b, overflow_b;
  logic [ACC_B-1:0] out_acc_b;
  logic [CW-1:0]    out_count_b;

  typedef struct {
    int acc;
    int cnt;
    int ovf;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   burst_vals[$];
  int   checks = 0;
  int   errors = 0;

  sum_accumulator #(.SUM_W(5), .ACC_W(ACC_A), .BURST_LEN(BL)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_sum(in_sum), .out_valid(out_valid_a), .out_ready(out_ready), .out_acc(out_acc_a),
    .out_count(out_count_a), .busy(busy_a), .overflow(overflow_a)
  );

  sum_accumulator #(.SUM_W(5), .ACC_W(ACC_B), .BURST_LEN(BL)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_sum(in_sum), .out_valid(out_valid_b), .out_ready(out_ready), .out_acc(out_acc_b),
    .out_count(out_count_b), .busy(busy_b), .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  // A running total crosses a multiple of 2^w exactly when the raw sum reaches 2^w
  function automatic int ovf_expected(input int raw, input int w);
`ifdef SUM_ACCUMULATOR_OVF_EN
    return (raw >= (1 << w)) ? 1 : 0;
`else
    return 0;
`endif
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid_a && out_ready) begin
      if (q_a.size() == 0) begin
        checkOutput("unexpected_result_a", 1, 0);
      end else begin
        e = q_a.pop_front();
        checkOutput("res_acc_a", int'(out_acc_a), e.acc);
        checkOutput("res_count_a", int'(out_count_a), e.cnt);
        checkOutput("res_ovf_a", int'(overflow_a), e.ovf);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid_b && out_ready) begin
      if (q_b.size() == 0) begin
        checkOutput("unexpected_result_b", 1, 0);
      end else begin
        e = q_b.pop_front();
        checkOutput("res_acc_b", int'(out_acc_b), e.acc);
        checkOutput("res_count_b", int'(out_count_b), e.cnt);
        checkOutput("res_ovf_b", int'(overflow_b), e.ovf);
      end
    end
  end

  task automatic check_all_zero(input string tag);
    checkOutput({tag, "_acc"}, int'(out_acc_a), 0);
    checkOutput({tag, "_count"}, int'(out_count_a), 0);
    checkOutput({tag, "_busy"}, int'(busy_a), 0);
    checkOutput({tag, "_in_ready"}, int'(in_ready_a), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid_a), 0);
    checkOutput({tag, "_ovf"}, int'(overflow_a), 0);
    checkOutput({tag, "_ovf_b"}, int'(overflow_b), 0);
  endtask

  // gap_mode: 0 none, 1 alternate, 2 random; start_after/reset_after < 0 disables
  task automatic applyStimulus(input int gap_mode, input int ready_delay,
                               input int start_after, input int reset_after);
    int   idx = 0;
    int   raw = 0;
    int   cyc = 0;
    bit   vld;
    bit   phase = 1'b1;
    bit   mid_started = 1'b0;
    exp_t e;

    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checkOutput("ready_after_start", int'(in_ready_a), 1);
    checkOutput("busy_after_start", int'(busy_a), 1);
    checkOutput("acc_cleared", int'(out_acc_a), 0);
    checkOutput("count_cleared", int'(out_count_a), 0);
    checkOutput("ovf_cleared_b", int'(overflow_b), 0);

    while (idx < BL) begin
      if (cyc > 200) begin
        checkOutput("burst_timeout", cyc, 200);
        break;
      end
      case (gap_mode)
        0:       vld = 1'b1;
        1:       vld = phase;
        default: vld = 1'($urandom_range(0, 1));
      endcase
      phase    = ~phase;
      in_valid = vld;
      in_sum   = vld ? 5'(burst_vals[idx]) : 5'($urandom);
      if (!mid_started && start_after >= 0 && idx == start_after) begin
        start       = 1'b1;
        mid_started = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (vld) begin
        raw += burst_vals[idx];
        idx++;
      end
      cyc++;
      if (reset_after >= 0 && idx == reset_after) begin
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check_all_zero("mid_reset");
        #2 rst_n = 1'b1;
        return;
      end
      if (idx < BL) begin
        checkOutput("acc_in_ready", int'(in_ready_a), 1);
        checkOutput("acc_out_valid", int'(out_valid_a), 0);
        checkOutput("run_count", int'(out_count_a), idx);
        checkOutput("run_acc_a", int'(out_acc_a), raw % (1 << ACC_A));
        checkOutput("run_acc_b", int'(out_acc_b), raw % (1 << ACC_B));
        checkOutput("run_ovf_b", int'(overflow_b), ovf_expected(raw, ACC_B));
      end
    end
    in_valid = 1'b0;

    e.acc = raw % (1 << ACC_A); e.cnt = BL; e.ovf = ovf_expected(raw, ACC_A);
    q_a.push_back(e);
    e.acc = raw % (1 << ACC_B); e.cnt = BL; e.ovf = ovf_expected(raw, ACC_B);
    q_b.push_back(e);

    checkOutput("out_valid_latency", int'(out_valid_a), 1);
    checkOutput("in_ready_done", int'(in_ready_a), 0);
    repeat (ready_delay) begin
      @(posedge clk); #1;
      checkOutput("hold_valid", int'(out_valid_a), 1);
      checkOutput("hold_acc", int'(out_acc_a), raw % (1 << ACC_A));
      checkOutput("hold_count", int'(out_count_a), BL);
      checkOutput("hold_acc_b", int'(out_acc_b), raw % (1 << ACC_B));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput("idle_busy", int'(busy_a), 0);
    checkOutput("idle_out_valid", int'(out_valid_a), 0);
    checkOutput("idle_in_ready", int'(in_ready_a), 0);
    checkOutput("idle_keep_acc", int'(out_acc_a), raw % (1 << ACC_A));
    checkOutput("idle_keep_count", int'(out_count_a), BL);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got expired expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    #12;
    check_all_zero("reset");
    rst_n = 1'b1;

    burst_vals = '{15, 12, 31, 31};
    applyStimulus(0, 0, -1, -1);
    applyStimulus(1, 0, -1, -1);

    burst_vals = '{31, 31, 31, 31};
    applyStimulus(0, 5, -1, -1);

    burst_vals = '{7, 9, 5, 3};
    applyStimulus(0, 1, 2, -1);

    burst_vals = '{5, 6, 20, 20};
    applyStimulus(0, 0, -1, 2);
    burst_vals = '{1, 2, 3, 4};
    applyStimulus(2, 0, -1, -1);

    for (int n = 0; n < 20; n++) begin
      burst_vals = {};
      for (int k = 0; k < BL; k++) burst_vals.push_back(int'($urandom_range(0, 31)));
      applyStimulus(2, int'($urandom_range(0, 3)), -1, -1);
    end

    repeat (3) @(posedge clk);
    checkOutput("queue_a_drained", q_a.size(), 0);
    checkOutput("queue_b_drained", q_b.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
# sum_accumulator

Downstream consumer for the 4-bit binary adder: collects a burst of `BURST_LEN` 5-bit sums over a valid/ready handshake and accumulates them into a wider register. When the burst completes, it presents the total and the sample count on a valid/ready output. It sits between the adder output `c` and any result sink (register file, display, scoreboard). It turns single combinational sums into a sequenced, back-pressurable result stream.

## Interface
Parameters:
- `SUM_W`, 5, width of each incoming sum (adder output width).
- `ACC_W`, 8, accumulator width; the accumulator wraps modulo 2^ACC_W.
- `BURST_LEN`, 4, samples per burst; must be ≥ 1.
- `CNT_W`, $clog2(BURST_LEN+1), derived; width of `out_count`.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle pulse that begins a burst; honoured only in IDLE.
- `in_valid`  in  1  `in_sum` is valid.
- `in_ready`  out  1  block accepts a sample this cycle.
- `in_sum`  in  SUM_W  unsigned sum from the adder.
- `out_valid`  out  1  `out_acc` and `out_count` hold a completed burst.
- `out_ready`  in  1  sink accepts the result.
- `out_acc`  out  ACC_W  accumulated total.
- `out_count`  out  CNT_W  samples accepted in the current or last burst.
- `busy`  out  1  high whenever state ≠ IDLE.
- `overflow`  out  1  sticky carry-out of the accumulator; see Configuration.

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE:
  - `in_ready`=0, `out_valid`=0.
  - `start`=1 clears `out_acc`, `out_count` and `overflow` on that edge, then moves to ACC.
- ACC:
  - `in_ready`=1, driven combinationally from state only and never from `in_valid`.
  - A sample is accepted on an edge with `in_valid && in_ready`. On that edge: `out_acc <= out_acc + zero-extended in_sum` (mod 2^ACC_W) and `out_count <= out_count + 1`.
  - When the accepted sample is number `BURST_LEN`, move to DONE on the same edge.
  - `in_valid`=0 cycles are gaps: no state change.
- DONE:
  - `out_valid`=1, `in_ready`=0.
  - `out_acc`, `out_count` and `overflow` are held stable while `out_ready`=0.
  - `out_valid && out_ready` returns to IDLE. The outputs keep their values until the next `start`.
- `start` in ACC or DONE is ignored.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values: state IDLE; `in_ready`=0, `out_valid`=0, `out_acc`=0, `out_count`=0, `busy`=0, `overflow`=0.
- Reset mid-burst (any state) aborts the burst asynchronously. No partial result is emitted.
- Cycle after `start`: `in_ready`=1.
- With `in_valid` held high, the burst takes BURST_LEN cycles in ACC. `out_valid` rises on the cycle after the last accept, so from the last accept to result the latency is 1 cycle.
- Earliest next `start` is the cycle after the output handshake, when the block is back in IDLE.
- `in_sum` is sampled only on accepting edges; its value at other times is don't-care.

## Configuration
- Macro: `SUM_ACCUMULATOR_OVF_EN`.
- Defined:
  - `overflow` sets on any accepting edge whose addition carries out of bit ACC_W-1.
  - It is sticky until the next `start` or reset.
  - `out_acc` still wraps.
- Undefined:
  - `overflow` is tied to 0 and there is no carry logic.
  - The port remains, so the interface is identical in both builds.

## Structure
- Package `sum_acc_pkg`:
  - `typedef enum logic [1:0] {IDLE, ACC, DONE} sum_acc_state_t`.
  - Default constants `SUM_W_DEF`=5, `ACC_W_DEF`=8, `BURST_LEN_DEF`=4.
- Single module, with no sub-module. The FSM, counter and accumulator are small enough to live inline.

## Test plan
- Defaults, `start`, then back-to-back sums 15 (1010+0101), 12 (0100+1000), 31, 31 -> `out_valid` one cycle after the 4th accept, `out_acc`=89, `out_count`=4, `overflow`=0.
- Same burst with `in_valid` low on alternate cycles -> same result (89/4). `in_ready` stays 1 throughout ACC and the count advances only on valid cycles.
- `ACC_W`=6 with `SUM_ACCUMULATOR_OVF_EN` defined, sums 31,31,31,31 -> `out_acc`=60, `overflow`=1. With the macro undefined -> `out_acc`=60, `overflow`=0.
- `out_ready` held low for 5 cycles in DONE -> `out_valid`, `out_acc` and `out_count` stable. Raising `out_ready` gives one handshake, then IDLE with `busy`=0.
- `start` pulsed in ACC after 2 samples (7, 9) -> ignored: count continues to 3 after the next accept, and the final total includes 16 plus the remaining samples.
- `rst_n` asserted after 2 accepts -> all outputs 0 immediately and IDLE. A new burst of 1,2,3,4 then yields `out_acc`=10.
